mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. Sits directly downstream of EX and of the control unit.
- Consumes the control unit's `store_mem`, `load_mem`, `size` and `sign` for the instruction in EX.
- Runs a req/ack transaction on the data-memory port, aligns and sign-extends load data, and registers the result into the MEM/WB pipeline register.
- Raises `mem_stall` while a transaction is pending, so upstream stages and the PC freeze.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_stage_load_align.sv | 26 ++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access sizes, FSM encoding and
// the byte-lane helpers used when launching a data-memory request.
package mem_stage_pkg;

    localparam logic [2:0] MEM_SIZE_B = 3'd1;
    localparam logic [2:0] MEM_SIZE_H = 3'd2;
    localparam logic [2:0] MEM_SIZE_W = 3'd4;

    typedef enum logic {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_REQ  = 1'b1
    } mem_state_e;

    // A size of 0 (or any unknown size) on a memory op is reported as misaligned.
    function automatic logic is_aligned(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            MEM_SIZE_B: is_aligned = 1'b1;
            MEM_SIZE_H: is_aligned = ~off[0];
            MEM_SIZE_W: is_aligned = (off == 2'b00);
            default:    is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            MEM_SIZE_B: be_of = 4'b0001 << off;
            MEM_SIZE_H: be_of = 4'b0011 << off;
            default:    be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] sz, input logic [31:0] sd);
        case (sz)
            MEM_SIZE_B: wdata_of = {4{sd[7:0]}};
            MEM_SIZE_H: wdata_of = {2{sd[15:0]}};
            default:    wdata_of = sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: shifts the addressed bytes of a read word down
// to bit 0 and sign- or zero-extends them to XLEN.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      size_i,
    input  logic            sign_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] sh;

    always_comb begin
        sh = rdata_i >> {addr_lo_i, 3'b000};
        case (size_i)
            MEM_SIZE_B: data_o = {{(XLEN-8){sign_i & sh[7]}}, sh[7:0]};
            MEM_SIZE_H: data_o = {{(XLEN-16){sign_i & sh[15]}}, sh[15:0]};
            default:    data_o = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: launches req/ack data-memory accesses,
// stalls upstream while one is pending, and fills the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_ex,
    input  logic [XLEN-1:0]   alu_result_ex,
    input  logic [XLEN-1:0]   store_data_ex,
    input  logic [4:0]        rd_ex,
    input  logic              wb_en_ex,
    input  logic              store_mem,
    input  logic              load_mem,
    input  logic [2:0]        size,
    input  logic              sign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign_err
);

    mem_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              mis_q, mis_d;

    logic [1:0]      off;
    logic            mem_op;
    logic            aligned;
    logic [XLEN-1:0] ld_data;

    assign off     = alu_result_ex[1:0];
    assign mem_op  = valid_ex & (load_mem | store_mem);
    assign aligned = is_aligned(size, off);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (off),
        .size_i    (size),
        .sign_i    (sign),
        .data_o    (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        mem_stall  = 1'b0;
        if (state_q == MEM_ST_IDLE) begin
            if (mem_op && aligned) begin
                state_d   = MEM_ST_REQ;
                mem_stall = 1'b1;
                we_d      = store_mem;
                addr_d    = {alu_result_ex[ADDR_W-1:2], 2'b00};
                be_d      = be_of(size, off);
                wdata_d   = wdata_of(size, store_data_ex);
            end else if (mem_op) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_ex;
                wb_data_d  = '0;
                mis_d      = 1'b1;
            end else if (valid_ex) begin
                wb_valid_d = 1'b1;
                wb_en_d    = wb_en_ex;
                wb_rd_d    = rd_ex;
                wb_data_d  = alu_result_ex;
            end
        end else begin
            // EX is frozen while we wait, so its fields still describe this access.
            mem_stall = ~dmem_ack;
            if (dmem_ack) begin
                state_d    = MEM_ST_IDLE;
                wb_valid_d = 1'b1;
                wb_en_d    = load_mem & wb_en_ex;
                wb_rd_d    = rd_ex;
                wb_data_d  = load_mem ? ld_data : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

    assign dmem_req     = (state_q == MEM_ST_REQ);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_en        = wb_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed plan cases, async reset mid-access,
// then randomized instructions against a byte-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_ex = 1'b0;
    logic [31:0] alu_result_ex = '0;
    logic [31:0] store_data_ex = '0;
    logic [4:0]  rd_ex = '0;
    logic        wb_en_ex = 1'b0;
    logic        store_mem = 1'b0;
    logic        load_mem = 1'b0;
    logic [2:0]  size = '0;
    logic        sign = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_ex      (valid_ex),
        .alu_result_ex (alu_result_ex),
        .store_data_ex (store_data_ex),
        .rd_ex         (rd_ex),
        .wb_en_ex      (wb_en_ex),
        .store_mem     (store_mem),
        .load_mem      (load_mem),
        .size          (size),
        .sign          (sign),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .mem_stall     (mem_stall),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: think in bytes and lanes, not in shifters.
    function automatic bit m_aligned(input int sz, input int off);
        return (sz == 1 || sz == 2 || sz == 4) && (off % sz == 0);
    endfunction

    function automatic logic [3:0] m_be(input int sz, input int off);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input int off, input int sz, input bit sg);
        longint val = 0;
        for (int i = 0; i < sz; i++) val += longint'(rdata[8*(off+i) +: 8]) << (8*i);
        if (sg && val >= (longint'(1) << (8*sz - 1))) val -= longint'(1) << (8*sz);
        return val[31:0];
    endfunction

    task automatic do_op(input bit v, input bit ld, input bit st, input int sz, input bit sg,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input bit wbe, input logic [31:0] rdata, input int waits);
        exp_t e;
        int   off;
        int   stalls;
        off = int'(addr[1:0]);
        valid_ex = v; load_mem = ld; store_mem = st; size = 3'(sz); sign = sg;
        alu_result_ex = addr; store_data_ex = sd; rd_ex = rd; wb_en_ex = wbe;
        dmem_ack = 1'b0;
        #1;
        if (v && (ld || st) && m_aligned(sz, off)) begin
            chk("launch_no_req", dmem_req, 1'b0);
            stalls = mem_stall;
            @(negedge clk);
            for (int k = 0; k <= waits; k++) begin
                if (k == waits) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                    e.en = ld && wbe; e.rd = rd; e.mis = 1'b0;
                    e.data = ld ? m_load(rdata, off, sz, sg) : 32'h0;
                    sbq.push_back(e);
                    #1;
                end
                chk("req_fields", {dmem_req, dmem_we, dmem_addr, dmem_be},
                    {1'b1, st, addr[31:2], 2'b00, m_be(sz, off)});
                if (st) chk("req_wdata", dmem_wdata, m_wdata(sz, sd));
                stalls += int'(mem_stall);
                if (k < waits) @(negedge clk);
            end
            chk("stall_cycles", stalls, waits + 1);
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
        end else begin
            if (v) begin
                e.mis = ld || st;
                e.en = e.mis ? 1'b0 : wbe;
                e.rd = rd;
                e.data = addr;
                sbq.push_back(e);
            end
            chk("no_stall_no_req", {mem_stall, dmem_req}, 2'b00);
            @(negedge clk);
        end
    endtask

    // Monitor: every MEM/WB instruction must match the next scoreboard entry.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (wb_valid) begin
                if (sbq.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("wb_en_rd_mis", {wb_en, wb_rd, misalign_err}, {mon_e.en, mon_e.rd, mon_e.mis});
                    if (!mon_e.mis) chk("wb_data", wb_data, mon_e.data);
                end
            end else begin
                chk("misalign_idle", misalign_err, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, r, sz;
        bit ld, st;
        #1 rst_n = 1'b0;
        #12;
        chk("reset_state", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_en,
                            wb_rd, wb_data, misalign_err, mem_stall}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1, 1, 0, 4, 1, 32'h100, 32'h0,  5'd5, 1, 32'hDEADBEEF, 0);
        do_op(1, 1, 0, 1, 1, 32'h103, 32'h0,  5'd6, 1, 32'h80FFFFFF, 3);
        do_op(1, 1, 0, 2, 0, 32'h102, 32'h0,  5'd7, 1, 32'h80011234, 1);
        do_op(1, 0, 1, 1, 0, 32'h201, 32'hAB, 5'd0, 0, 32'h0, 1);
        do_op(1, 1, 0, 4, 0, 32'h102, 32'h0,  5'd8, 1, 32'h0, 0);
        do_op(1, 0, 0, 0, 0, 32'h1234_5678, 32'h0, 5'd9, 1, 32'h0, 0);
        do_op(0, 1, 0, 4, 0, 32'h100, 32'h0,  5'd3, 1, 32'h0, 0);

        // Async reset while a load is outstanding; the late ack must be ignored.
        valid_ex = 1'b1; load_mem = 1'b1; store_mem = 1'b0; size = 3'd4;
        alu_result_ex = 32'h300; rd_ex = 5'd4; wb_en_ex = 1'b1;
        @(negedge clk);
        chk("rst_pre_req", dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        valid_ex = 1'b0;
        #1;
        chk("rst_async_clear", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, mem_stall}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rst_ack_ignored", {dmem_req, mem_stall}, 2'b00);
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            r = $urandom_range(0, 7);
            sz = (r == 0) ? 0 : (r <= 2) ? 1 : (r <= 4) ? 2 : 4;
            ld = (kind >= 4 && kind <= 6) || (kind == 0 && $urandom_range(0, 1) == 1);
            st = (kind >= 7);
            do_op(kind != 0, ld, st, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3));
        end

        valid_ex = 1'b0; load_mem = 1'b0; store_mem = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
